// File: rtl/iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : iter_muldiv
// Description : Iterative radix-2 unsigned multiply / divide unit
//               (MUL, MULH, DIVU, REMU) with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             vout,
    output logic             dzout
);

    localparam logic [1:0]      c_OP_MUL  = 2'b00;
    localparam logic [1:0]      c_OP_MULH = 2'b01;
    localparam logic [1:0]      c_OP_DIVU = 2'b10;
    localparam logic [CNTW-1:0] c_LAST    = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_b;
    logic [CNTW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   r_dout;
    logic               r_vout;
    logic               r_dz;
    logic [WIDTH-1:0]   w_result;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_accept;
    logic               w_finish;
    logic               w_dz;

    assign w_dz     = r_op[1] & (r_b == '0);
    assign w_finish = w_dz | (r_cnt == c_LAST);

    // Multiply: add b into the upper half on a set LSB, then shift right.
    // Divide: shift left, trial-subtract b, keep the difference if non-negative.
    always_comb begin
        w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
        w_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
        if (!r_op[1]) begin
            w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        end else if (w_diff[WIDTH]) begin
            w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
        end else begin
            w_acc_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
    end

    // On divide-by-zero the accumulator low half still holds the dividend.
    always_comb begin
        case (r_op)
            c_OP_MUL:  w_result = w_acc_nxt[WIDTH-1:0];
            c_OP_MULH: w_result = w_acc_nxt[2*WIDTH-1:WIDTH];
            c_OP_DIVU: w_result = w_dz ? {WIDTH{1'b1}} : w_acc_nxt[WIDTH-1:0];
            default:   w_result = w_dz ? r_acc[WIDTH-1:0] : w_acc_nxt[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_finish) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_op   <= 2'b00;
            r_b    <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_dout <= '0;
            r_vout <= 1'b0;
            r_dz   <= 1'b0;
        end else if (flush) begin
            r_cnt  <= '0;
            r_dout <= '0;
            r_vout <= 1'b0;
            r_dz   <= 1'b0;
        end else if (w_accept) begin
            r_op   <= op;
            r_b    <= din_b;
            r_cnt  <= '0;
            r_acc  <= {{WIDTH{1'b0}}, din_a};
            r_dout <= '0;
            r_vout <= 1'b0;
            r_dz   <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_finish) begin
                r_dout <= w_result;
                r_vout <= ~r_op[1] & (|w_acc_nxt[2*WIDTH-1:WIDTH]);
                r_dz   <= w_dz;
            end
        end
    end

    assign dout  = r_dout;
    assign vout  = r_vout;
    assign dzout = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_muldiv
// Description : Directed self-checking bench for iter_muldiv (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_muldiv;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset_b;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] din_a;
    logic [WIDTH-1:0] din_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             vout;
    logic             dzout;

    int n_checks;
    int n_errors;

    iter_muldiv #(.WIDTH(WIDTH), .CNTW(6)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .din_a     (din_a),
        .din_b     (din_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .vout      (vout),
        .dzout     (dzout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after the accepting edge; waits for the result, then
    // holds out_ready low for 'hold' cycles before completing the handshake.
    task automatic finish_op(input string tag, input logic [31:0] ed, input logic ev,
                             input logic edz, input int lat, input int hold);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ":latency"}, 64'(n), 64'(lat));
        chk({tag, ":dout"}, 64'(dout), 64'(ed));
        chk({tag, ":vout"}, 64'(vout), 64'(ev));
        chk({tag, ":dzout"}, 64'(dzout), 64'(edz));
        chk({tag, ":in_ready_busy"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, ":hold_dout"}, 64'(dout), 64'(ed));
            chk({tag, ":hold_vout"}, 64'(vout), 64'(ev));
            chk({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ":valid_after"}, 64'(out_valid), 64'd0);
        chk({tag, ":in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    // Entered at posedge+1; operands are scrambled right after acceptance.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ed, input logic ev,
                          input logic edz, input int lat, input int hold);
        chk({tag, ":in_ready"}, 64'(in_ready), 64'd1);
        op       = o;
        din_a    = a;
        din_b    = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = 2'($urandom);
        din_a    = $urandom;
        din_b    = $urandom;
        finish_op(tag, ed, ev, edz, lat, hold);
    endtask

    initial begin
        int seen;
        n_checks  = 0;
        n_errors  = 0;
        reset_b   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'b00;
        din_a     = '0;
        din_b     = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst:out_valid", 64'(out_valid), 64'd0);
        chk("rst:dout", 64'(dout), 64'd0);
        chk("rst:vout", 64'(vout), 64'd0);
        chk("rst:dzout", 64'(dzout), 64'd0);
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk); #1;
        chk("rst:in_ready", 64'(in_ready), 64'd1);

        run_op("mul_ovf",  2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0, 32, 0);
        run_op("mulh_ovf", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b1, 1'b0, 32, 0);
        run_op("divu",     2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 32, 0);
        run_op("remu",     2'b11, 32'd100, 32'd7, 32'd2,  1'b0, 1'b0, 32, 0);
        run_op("divu_z",   2'b10, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1, 0);
        run_op("remu_z",   2'b11, 32'h1234, 32'h0, 32'h0000_1234, 1'b0, 1'b1, 1, 0);
        run_op("mul_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32, 5);
        run_op("mulh_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 32, 0);
        run_op("mul_zero", 2'b00, 32'h0, 32'h1234, 32'h0, 1'b0, 1'b0, 32, 0);
        run_op("mul_small",2'b00, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 32, 0);
        run_op("divu_one", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32, 0);
        run_op("remu_16",  2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, 1'b0, 32, 0);
        run_op("divu_lt",  2'b10, 32'd5, 32'd9, 32'd0, 1'b0, 1'b0, 32, 0);
        run_op("remu_lt",  2'b11, 32'd5, 32'd9, 32'd5, 1'b0, 1'b0, 32, 0);

        // Flush mid-operation while a new request is already presented.
        op = 2'b00; din_a = 32'hFFFF_FFFF; din_b = 32'h3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("flush:busy_valid", 64'(out_valid), 64'd0);
        op = 2'b10; din_a = 32'd100; din_b = 32'd7; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        chk("flush:in_ready", 64'(in_ready), 64'd1);
        chk("flush:out_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        @(posedge clk); #1;
        chk("flush:accepted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        finish_op("post_flush", 32'd14, 1'b0, 1'b0, 32, 0);

        // Asynchronous reset in the middle of a multiply.
        op = 2'b01; din_a = 32'hFFFF_FFFF; din_b = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_b = 1'b0;
        #1;
        chk("rstbusy:in_ready", 64'(in_ready), 64'd1);
        chk("rstbusy:out_valid", 64'(out_valid), 64'd0);
        chk("rstbusy:dout", 64'(dout), 64'd0);
        chk("rstbusy:vout", 64'(vout), 64'd0);
        chk("rstbusy:dzout", 64'(dzout), 64'd0);
        @(negedge clk);
        reset_b = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rstbusy:stale_valid", 64'(seen), 64'd0);
        chk("rstbusy:in_ready_after", 64'(in_ready), 64'd1);

        run_op("after_rst", 2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 32, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
